// File: rtl/alu_seq.sv
// Command sequencer feeding an 8-bit combinational ALU; accumulator-based, iterates 1-bit shifts.
// Optional flag outputs (out_zero, out_carry) are enabled by defining ALU_SEQ_FLAGS_EN.
module alu_seq #(
    parameter int unsigned CNT_W = 3,
    localparam int unsigned DATA_W = 8,
    localparam int unsigned OP_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CNT_W-1:0]  in_cnt,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef ALU_SEQ_FLAGS_EN
    output logic              out_zero,
    output logic              out_carry,
`endif
    output logic              busy
);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SHR = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SHL = OP_W'(3);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   w_b_nxt;
    logic [OP_W-1:0]     r_op;
    logic [OP_W-1:0]     w_op_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_in_shift;

    assign w_in_shift = (in_op == OP_SHR) || (in_op == OP_SHL);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_b     <= w_b_nxt;
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_b_nxt     = r_b;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_load) begin
                        w_acc_nxt = in_data;
                    end else begin
                        w_b_nxt  = in_data;
                        w_op_nxt = in_op;
                        if (w_in_shift) begin
                            w_cnt_nxt   = in_cnt;
                            w_state_nxt = (in_cnt == '0) ? S_RESULT : S_EXEC;
                        end else begin
                            w_cnt_nxt   = CNT_W'(1);
                            w_state_nxt = S_EXEC;
                        end
                    end
                end
            end
            S_EXEC: begin
                w_acc_nxt = alu_q;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign alu_a     = r_acc;
    assign alu_b     = r_b;
    assign alu_op    = r_op;
    assign out_data  = r_acc;
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_RESULT);
    assign busy      = (r_state != S_IDLE);

`ifdef ALU_SEQ_FLAGS_EN
    logic r_zero;
    logic r_carry;
    logic w_zero_nxt;
    logic w_carry_nxt;

    // Flags track the last EXEC iteration only
    always_comb begin
        w_zero_nxt  = r_zero;
        w_carry_nxt = r_carry;
        if (r_state == S_EXEC) begin
            w_zero_nxt = (alu_q == '0);
            case (r_op)
                OP_ADD:  w_carry_nxt = (alu_q < r_acc);
                OP_SUB:  w_carry_nxt = (r_acc < r_b);
                OP_SHR:  w_carry_nxt = r_acc[0];
                OP_SHL:  w_carry_nxt = r_acc[DATA_W-1];
                default: w_carry_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_zero  <= w_zero_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    assign out_zero  = r_zero;
    assign out_carry = r_carry;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a behavioural model of the downstream ALU.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_load;
    logic [2:0] in_op;
    logic [7:0] in_data;
    logic [2:0] in_cnt;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_q;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic       out_zero;
    logic       out_carry;
`endif

    int checks   = 0;
    int failures = 0;

    alu_seq #(.CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_load   (in_load),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_q     (alu_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef ALU_SEQ_FLAGS_EN
        .out_zero  (out_zero),
        .out_carry (out_carry),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Downstream ALU: 1-bit logical shifts of a, ops 6/7 clear
    always_comb begin
        case (alu_op)
            3'd0:    alu_q = alu_a + alu_b;
            3'd1:    alu_q = alu_a - alu_b;
            3'd2:    alu_q = alu_a >> 1;
            3'd3:    alu_q = alu_a << 1;
            3'd4:    alu_q = alu_a & alu_b;
            3'd5:    alu_q = alu_a | alu_b;
            default: alu_q = 8'h00;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for exactly one edge; caller ensures the DUT is idle
    task automatic send(input logic ld, input logic [2:0] op, input logic [7:0] d,
                        input logic [2:0] c);
        in_valid = 1'b1;
        in_load  = ld;
        in_op    = op;
        in_data  = d;
        in_cnt   = c;
        step();
        in_valid = 1'b0;
        in_load  = 1'b0;
        in_op    = 3'd7;
        in_data  = 8'hEE;
        in_cnt   = 3'd5;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL reset_hs {in_ready,out_valid,busy}=%b exp=100", {in_ready, out_valid, busy});
        end
        checks++;
        if ({out_data, alu_a, alu_b, alu_op} !== 27'h0) begin
            failures++;
            $display("FAIL reset_data out=%h a=%h b=%h op=%h exp all zero", out_data, alu_a, alu_b, alu_op);
        end
`ifdef ALU_SEQ_FLAGS_EN
        checks++;
        if ({out_zero, out_carry} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags zc=%b exp=00", {out_zero, out_carry});
        end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        send(1'b1, 3'd0, 8'h05, 3'd0);
        checks++;
        if ({in_ready, out_valid, out_data} !== {2'b10, 8'h05}) begin
            failures++;
            $display("FAIL load5 rdy=%b vld=%b out=%h exp rdy=1 vld=0 out=05", in_ready, out_valid, out_data);
        end
        send(1'b0, 3'd0, 8'h03, 3'd6);
        checks++;
        if ({in_ready, out_valid, busy, alu_a, alu_b, alu_op} !== {3'b001, 8'h05, 8'h03, 3'd0}) begin
            failures++;
            $display("FAIL add_exec rdy=%b vld=%b busy=%b a=%h b=%h op=%0d exp 0,0,1,05,03,0",
                     in_ready, out_valid, busy, alu_a, alu_b, alu_op);
        end
        step();
        checks++;
        if ({in_ready, out_valid, out_data} !== {2'b01, 8'h08}) begin
            failures++;
            $display("FAIL add_result rdy=%b vld=%b out=%h exp rdy=0 vld=1 out=08", in_ready, out_valid, out_data);
        end
`ifdef ALU_SEQ_FLAGS_EN
        checks++;
        if ({out_zero, out_carry} !== 2'b00) begin
            failures++;
            $display("FAIL add_flags zc=%b exp=00", {out_zero, out_carry});
        end
`endif
        step();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL add_idle {rdy,vld,busy}=%b exp=100", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_wrap_sub();
        send(1'b1, 3'd0, 8'hF0, 3'd0);
        send(1'b0, 3'd0, 8'h20, 3'd0);
        step();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h10}) begin
            failures++;
            $display("FAIL add_wrap vld=%b out=%h exp vld=1 out=10", out_valid, out_data);
        end
`ifdef ALU_SEQ_FLAGS_EN
        checks++;
        if ({out_zero, out_carry} !== 2'b01) begin
            failures++;
            $display("FAIL wrap_flags zc=%b exp=01", {out_zero, out_carry});
        end
`endif
        step();
        send(1'b0, 3'd1, 8'h10, 3'd0);
        step();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h00}) begin
            failures++;
            $display("FAIL sub_zero vld=%b out=%h exp vld=1 out=00", out_valid, out_data);
        end
`ifdef ALU_SEQ_FLAGS_EN
        checks++;
        if ({out_zero, out_carry} !== 2'b10) begin
            failures++;
            $display("FAIL sub_flags zc=%b exp=10", {out_zero, out_carry});
        end
`endif
        step();
    endtask

    task automatic test_shift();
        int exec_cycles;
        exec_cycles = 0;
        send(1'b1, 3'd0, 8'h81, 3'd0);
        send(1'b0, 3'd3, 8'h00, 3'd3);
        for (int i = 0; i < 8 && busy && !out_valid; i++) begin
            if (alu_op == 3'd3) exec_cycles++;
            step();
        end
        checks++;
        if (exec_cycles !== 3) begin
            failures++;
            $display("FAIL shl_iters got=%0d exp=3", exec_cycles);
        end
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h08}) begin
            failures++;
            $display("FAIL shl_result vld=%b out=%h exp vld=1 out=08", out_valid, out_data);
        end
`ifdef ALU_SEQ_FLAGS_EN
        checks++;
        if ({out_zero, out_carry} !== 2'b00) begin
            failures++;
            $display("FAIL shl_flags zc=%b exp=00", {out_zero, out_carry});
        end
`endif
        step();
        send(1'b0, 3'd2, 8'h00, 3'd0);
        checks++;
        if ({out_valid, alu_op, out_data} !== {1'b1, 3'd2, 8'h08}) begin
            failures++;
            $display("FAIL shr_cnt0 vld=%b op=%0d out=%h exp vld=1 op=2 out=08", out_valid, alu_op, out_data);
        end
        step();
    endtask

    task automatic test_backpressure();
        send(1'b1, 3'd0, 8'h3C, 3'd0);
        out_ready = 1'b0;
        send(1'b0, 3'd4, 8'h0F, 3'd0);
        step();
        in_valid = 1'b1;
        in_load  = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({in_ready, out_valid, out_data} !== {2'b01, 8'h0C}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d rdy=%b vld=%b out=%h exp rdy=0 vld=1 out=0C",
                         i, in_ready, out_valid, out_data);
            end
            step();
        end
        in_valid  = 1'b0;
        in_load   = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid, out_data} !== {2'b10, 8'h0C}) begin
            failures++;
            $display("FAIL bp_release rdy=%b vld=%b out=%h exp rdy=1 vld=0 out=0C", in_ready, out_valid, out_data);
        end
    endtask

    task automatic test_back_to_back();
        send(1'b1, 3'd0, 8'h00, 3'd0);
        send(1'b0, 3'd5, 8'h01, 3'd0);
        step();
        step();
        send(1'b0, 3'd0, 8'h01, 3'd0);
        step();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h02}) begin
            failures++;
            $display("FAIL b2b_result vld=%b out=%h exp vld=1 out=02", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_reset_mid_exec();
        int seen_valid;
        seen_valid = 0;
        send(1'b1, 3'd0, 8'hFF, 3'd0);
        send(1'b0, 3'd2, 8'h00, 3'd7);
        step();
        step();
        checks++;
        if ({busy, alu_a} !== {1'b1, 8'h3F}) begin
            failures++;
            $display("FAIL shr_progress busy=%b a=%h exp busy=1 a=3F", busy, alu_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, out_data, alu_a, alu_b, alu_op} !== {3'b100, 27'h0}) begin
            failures++;
            $display("FAIL rst_mid rdy=%b vld=%b busy=%b out=%h a=%h b=%h op=%h exp 1,0,0 and zeros",
                     in_ready, out_valid, busy, out_data, alu_a, alu_b, alu_op);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) seen_valid++;
        end
        checks++;
        if ({seen_valid[3:0], out_data} !== {4'd0, 8'h00}) begin
            failures++;
            $display("FAIL rst_abandon valid_cycles=%0d out=%h exp 0 and 00", seen_valid, out_data);
        end
    endtask

    task automatic test_clear_and_load();
        int seen_valid;
        seen_valid = 0;
        send(1'b1, 3'd0, 8'hAA, 3'd0);
        for (int i = 0; i < 3; i++) begin
            if (out_valid) seen_valid++;
            step();
        end
        checks++;
        if ({seen_valid[3:0], out_data, in_ready} !== {4'd0, 8'hAA, 1'b1}) begin
            failures++;
            $display("FAIL load_no_result valid_cycles=%0d out=%h rdy=%b exp 0, AA, 1", seen_valid, out_data, in_ready);
        end
        send(1'b0, 3'd6, 8'h55, 3'd0);
        checks++;
        if ({busy, alu_op} !== {1'b1, 3'd6}) begin
            failures++;
            $display("FAIL clr_exec busy=%b op=%0d exp busy=1 op=6", busy, alu_op);
        end
        step();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h00}) begin
            failures++;
            $display("FAIL clr_result vld=%b out=%h exp vld=1 out=00", out_valid, out_data);
        end
`ifdef ALU_SEQ_FLAGS_EN
        checks++;
        if ({out_zero, out_carry} !== 2'b10) begin
            failures++;
            $display("FAIL clr_flags zc=%b exp=10", {out_zero, out_carry});
        end
`endif
        step();
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_load   = 1'b0;
        in_op     = 3'd0;
        in_data   = 8'h00;
        in_cnt    = 3'd0;
        out_ready = 1'b1;
        test_reset();
        test_add();
        test_wrap_sub();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_exec();
        test_clear_and_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
